data_mem_bridge: RTL and testbench
==================================

// Module: data_mem_bridge
// PURPOSE
//  Downstream stage of the bus control block: consumes its registered data-bus request
//  (address, write data, read/write flag) and drives the synchronous data SRAM.
//  Posts requests into a small in-order queue, stretches each SRAM access by WAIT_STATES,
//  and returns read data to the core with a one-cycle valid pulse. o_Listo stalls the core.
// PARAMETERS
//  DATA_W       8  data bus width
//  ADDR_W       8  address bus width
//  WAIT_STATES  1  extra SRAM cycles per access, legal 0..7
//  FIFO_DEPTH   2  request queue entries, power of two, >=2
// PORTS
//  Clk                  in   1       system clock, all state on rising edge
//  Rst_n                in   1       asynchronous, active-low reset
//  i_Req                in   1       request strobe from bus control (one per transaction)
//  i_Lectura_Escritura  in   1       0 = read (LOAD), 1 = write (STORE)
//  i_Direccion          in   ADDR_W  request address
//  i_Dato               in   DATA_W  write data (ignored on reads)
//  o_Listo              out  1       bridge can accept a request this cycle
//  o_Dato_Leido         out  DATA_W  read data, held until next read completes
//  o_Dato_Valido        out  1       one-cycle pulse: o_Dato_Leido updated
//  o_Mem_En             out  1       SRAM enable
//  o_Mem_We             out  1       SRAM write enable (only with o_Mem_En)
//  o_Mem_Addr           out  ADDR_W  SRAM address
//  o_Mem_WData          out  DATA_W  SRAM write data
//  i_Mem_RData          in   DATA_W  SRAM read data, valid at last access edge
// BEHAVIOUR
//  Reset (Rst_n=0, async): all outputs 0, queue emptied, FSM=IDLE, wait counter 0.
//   Assert/deassert anywhere incl. mid-access: o_Mem_En drops immediately; access abandoned,
//   no o_Dato_Valido. After release, o_Listo=1 from the first edge.
//  Handshake: request accepted on edge where i_Req && o_Listo; pushed into queue.
//   o_Listo = !queue_full && !read_pending. read_pending set when a read is accepted,
//   cleared on the edge that raises o_Dato_Valido (max one outstanding read).
//   i_Req while o_Listo=0: ignored, not queued; requester must hold/retry.
//  Ordering: strictly in-order; a read queued behind writes sees their data.
//  FSM: IDLE -> ACCESS when queue non-empty (pop on that edge, load mem regs).
//   ACCESS: o_Mem_En=1, o_Mem_We/Addr/WData stable for WAIT_STATES+1 cycles (counter).
//   Last ACCESS edge: if read, o_Dato_Leido<=i_Mem_RData, o_Dato_Valido<=1 for 1 cycle.
//   Then -> ACCESS again (pop next, back-to-back, o_Mem_En stays 1) if queue non-empty,
//   else -> IDLE (o_Mem_* cleared to 0).
//  Latency (queue empty at accept edge A): o_Mem_En high from edge A+1; read data valid
//   (o_Dato_Valido=1) after edge A+2+WAIT_STATES; write complete at same edge.
//  Simultaneous push+pop same edge: allowed; count unchanged; pointers wrap mod FIFO_DEPTH.
//  Full: o_Listo=0 combinationally; pop on an edge frees entry, o_Listo=1 next cycle.
//  Widths: no arithmetic on address/data; counter width 3 bits, saturates at WAIT_STATES.
// STRUCTURE
//  Package data_mem_pkg: FSM state enum (IDLE, ACCESS), request record {we, addr, data},
//   DATA_W/ADDR_W defaults, WAIT_CNT_W=3.
//  Sub-module bus_req_fifo: synchronous FIFO of request records, full/empty flags,
//   async active-low reset, same-edge push/pop.
//  Top: handshake logic, read_pending flag, FSM + wait counter, output registers.
// TESTING
//  1 Reset: Rst_n=0 mid-ACCESS (WAIT_STATES=3, cycle 2) -> o_Mem_En=0 at once, no valid pulse.
//  2 Write 0x5A to 0x10, WAIT_STATES=0 -> o_Mem_En=o_Mem_We=1, Addr=0x10, WData=0x5A, 1 cycle.
//  3 Write 0x33@0x20 then read 0x20 back-to-back, SRAM model -> o_Dato_Leido=0x33, one pulse.
//  4 WAIT_STATES=2, read 0x40 (mem=0xC3) -> o_Mem_En 3 cycles, valid after edge A+4, data 0xC3.
//  5 Three writes on consecutive cycles, FIFO_DEPTH=2, WAIT_STATES=1 -> o_Listo low when
//    full, third accepted later, SRAM sees all three in order, none lost or duplicated.
//  6 Second read issued while first outstanding -> o_Listo=0, not queued until first valid.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data-SRAM bridge: FSM states, request record, widths.
package data_mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int WAIT_CNT_W = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Request record at default widths; the top packs the same fields at its own widths.
    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } req_t;

endpackage

// File: rtl/bus_req_fifo.sv
// In-order request queue: synchronous push/pop (same edge allowed), full/empty flags.
module bus_req_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= wdata;
    end

    assign rdata = store[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/data_mem_bridge.sv
// Bridges registered bus-control requests onto the synchronous data SRAM with wait states.
module data_mem_bridge
    import data_mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_STATES = 1,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              i_Req,
    input  logic              i_Lectura_Escritura,
    input  logic [ADDR_W-1:0] i_Direccion,
    input  logic [DATA_W-1:0] i_Dato,
    output logic              o_Listo,
    output logic [DATA_W-1:0] o_Dato_Leido,
    output logic              o_Dato_Valido,
    output logic              o_Mem_En,
    output logic              o_Mem_We,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [DATA_W-1:0] o_Mem_WData,
    input  logic [DATA_W-1:0] i_Mem_RData
);

    localparam int REQ_W = 1 + ADDR_W + DATA_W;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_STATES);

    state_t                state, state_n;
    logic [WAIT_CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic                  mem_en_n, mem_we_n;
    logic [ADDR_W-1:0]     mem_addr_n;
    logic [DATA_W-1:0]     mem_wdata_n;
    logic [DATA_W-1:0]     dato_leido_n;
    logic                  dato_valido_n;
    logic                  read_pending, read_pending_n;
    logic                  out_of_reset;

    logic                  accept, pop;
    logic                  fifo_full, fifo_empty;
    logic [REQ_W-1:0]      head;

    // o_Listo is held low while in reset and rises from the first edge after release.
    assign o_Listo = out_of_reset && !fifo_full && !read_pending;
    assign accept  = i_Req && o_Listo;

    bus_req_fifo #(
        .W     (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Rst_n),
        .push  (accept),
        .wdata ({i_Lectura_Escritura, i_Direccion, i_Dato}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            o_Mem_En      <= 1'b0;
            o_Mem_We      <= 1'b0;
            o_Mem_Addr    <= '0;
            o_Mem_WData   <= '0;
            o_Dato_Leido  <= '0;
            o_Dato_Valido <= 1'b0;
            read_pending  <= 1'b0;
            out_of_reset  <= 1'b0;
        end else begin
            state         <= state_n;
            wait_cnt      <= wait_cnt_n;
            o_Mem_En      <= mem_en_n;
            o_Mem_We      <= mem_we_n;
            o_Mem_Addr    <= mem_addr_n;
            o_Mem_WData   <= mem_wdata_n;
            o_Dato_Leido  <= dato_leido_n;
            o_Dato_Valido <= dato_valido_n;
            read_pending  <= read_pending_n;
            out_of_reset  <= 1'b1;
        end
    end

    always_comb begin
        state_n        = state;
        wait_cnt_n     = wait_cnt;
        mem_en_n       = o_Mem_En;
        mem_we_n       = o_Mem_We;
        mem_addr_n     = o_Mem_Addr;
        mem_wdata_n    = o_Mem_WData;
        dato_leido_n   = o_Dato_Leido;
        dato_valido_n  = 1'b0;
        read_pending_n = read_pending;
        pop            = 1'b0;

        if (accept && !i_Lectura_Escritura) read_pending_n = 1'b1;

        case (state)
            IDLE: begin
                if (!fifo_empty) pop = 1'b1;
            end
            ACCESS: begin
                if (wait_cnt == WAIT_LAST) begin
                    if (!o_Mem_We) begin
                        dato_leido_n   = i_Mem_RData;
                        dato_valido_n  = 1'b1;
                        read_pending_n = 1'b0;
                    end
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_n     = IDLE;
                        mem_en_n    = 1'b0;
                        mem_we_n    = 1'b0;
                        mem_addr_n  = '0;
                        mem_wdata_n = '0;
                    end
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Popping always starts a fresh access, back-to-back when already in ACCESS.
        if (pop) begin
            state_n     = ACCESS;
            wait_cnt_n  = '0;
            mem_en_n    = 1'b1;
            mem_we_n    = head[REQ_W-1];
            mem_addr_n  = head[DATA_W +: ADDR_W];
            mem_wdata_n = head[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Directed bench: four bridges with WAIT_STATES 0..3 share one clock and reset.
module tb_data_mem_bridge;
    import data_mem_pkg::*;

    localparam int NI  = 4;
    localparam int RW  = $bits(req_t);

    logic       clk;
    logic       rst_n;
    logic       req    [NI];
    logic       lw     [NI];
    logic [7:0] addr   [NI];
    logic [7:0] din    [NI];
    logic       listo  [NI];
    logic [7:0] dout   [NI];
    logic       valid  [NI];
    logic       men    [NI];
    logic       mwe    [NI];
    logic [7:0] maddr  [NI];
    logic [7:0] mwdata [NI];
    logic [7:0] rdata  [NI];

    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] obs_q [$];

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each bridge g runs with WAIT_STATES=g; unwritten SRAM words read back addr ^ 0x83.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        bit [7:0] sram    [256];
        bit       written [256];

        data_mem_bridge #(
            .DATA_W      (8),
            .ADDR_W      (8),
            .WAIT_STATES (g),
            .FIFO_DEPTH  (2)
        ) u_dut (
            .Clk                 (clk),
            .Rst_n               (rst_n),
            .i_Req               (req[g]),
            .i_Lectura_Escritura (lw[g]),
            .i_Direccion         (addr[g]),
            .i_Dato              (din[g]),
            .o_Listo             (listo[g]),
            .o_Dato_Leido        (dout[g]),
            .o_Dato_Valido       (valid[g]),
            .o_Mem_En            (men[g]),
            .o_Mem_We            (mwe[g]),
            .o_Mem_Addr          (maddr[g]),
            .o_Mem_WData         (mwdata[g]),
            .i_Mem_RData         (rdata[g])
        );

        assign rdata[g] = written[maddr[g]] ? sram[maddr[g]] : (maddr[g] ^ 8'h83);

        always @(posedge clk) begin
            if (men[g] && mwe[g]) begin
                sram[maddr[g]]    <= mwdata[g];
                written[maddr[g]] <= 1'b1;
            end
        end

        if (g == 1) begin : g_log
            always @(posedge clk) begin
                if (men[g] && mwe[g]) obs_q.push_back({1'b1, maddr[g], mwdata[g]});
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one request and holds it until accepted; returns #1 after the accept edge.
    task automatic send(input int k, input logic we, input logic [7:0] a, input logic [7:0] d);
        int n;
        n = 0;
        lw[k] = we; addr[k] = a; din[k] = d; req[k] = 1'b1;
        while (!listo[k] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!listo[k]) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req[k] = 1'b0;
    endtask

    initial begin
        int         cnt;
        int         edge_at;
        int         acc_at;
        logic       l;
        logic       seen;
        logic [7:0] cap;

        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req[k] = 1'b0; lw[k] = 1'b0; addr[k] = '0; din[k] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_listo", listo[0], 1'b0);
        chk("rst_mem_en", men[0], 1'b0);
        chk("rst_valid", valid[0], 1'b0);
        chk("rst_dout", dout[0], 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("listo_first_edge", listo[0], 1'b1);

        // Reset in the second ACCESS cycle of a WAIT_STATES=3 read
        send(3, 1'b0, 8'h60, 8'h00);
        @(posedge clk); #1;
        chk("t1_mem_en_a1", men[3], 1'b1);
        @(posedge clk); #1;
        chk("t1_mem_en_a2", men[3], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t1_mem_en_async", men[3], 1'b0);
        chk("t1_listo_in_rst", listo[3], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk("t1_listo_after_rel", listo[3], 1'b1);
            if (valid[3] || men[3]) cnt++;
        end
        chk("t1_no_activity", cnt, 0);

        // Single write, WAIT_STATES=0
        send(0, 1'b1, 8'h10, 8'h5A);
        @(posedge clk); #1;
        chk("t2_mem_en", men[0], 1'b1);
        chk("t2_mem_we", mwe[0], 1'b1);
        chk("t2_mem_addr", maddr[0], 8'h10);
        chk("t2_mem_wdata", mwdata[0], 8'h5A);
        @(posedge clk); #1;
        chk("t2_one_cycle", men[0], 1'b0);

        // Write then read of the same address on consecutive cycles
        req[0] = 1'b1; lw[0] = 1'b1; addr[0] = 8'h20; din[0] = 8'h33;
        @(posedge clk); #1;
        chk("t3_b2b_listo", listo[0], 1'b1);
        lw[0] = 1'b0;
        @(posedge clk); #1;
        req[0] = 1'b0;
        cnt = 0; cap = '0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (valid[0]) begin cnt++; cap = dout[0]; end
        end
        chk("t3_pulses", cnt, 1);
        chk("t3_rdata", cap, 8'h33);

        // Read with WAIT_STATES=2: enable 3 cycles, valid after edge A+4
        send(2, 1'b0, 8'h40, 8'h00);
        cnt = 0; edge_at = 0; cap = '0;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            if (men[2]) cnt++;
            if (valid[2] && edge_at == 0) begin edge_at = i; cap = dout[2]; end
        end
        chk("t4_en_cycles", cnt, 3);
        chk("t4_valid_edge", edge_at, 4);
        chk("t4_rdata", cap, 8'hC3);

        // Back-to-back writes into a 2-deep queue, WAIT_STATES=1; each write spans two edges
        exp_q.push_back({1'b1, 8'h01, 8'h11}); exp_q.push_back({1'b1, 8'h01, 8'h11});
        exp_q.push_back({1'b1, 8'h02, 8'h22}); exp_q.push_back({1'b1, 8'h02, 8'h22});
        exp_q.push_back({1'b1, 8'h03, 8'h33}); exp_q.push_back({1'b1, 8'h03, 8'h33});
        exp_q.push_back({1'b1, 8'h04, 8'h44}); exp_q.push_back({1'b1, 8'h04, 8'h44});
        send(1, 1'b1, 8'h01, 8'h11);
        send(1, 1'b1, 8'h02, 8'h22);
        send(1, 1'b1, 8'h03, 8'h33);
        chk("t5_listo_full", listo[1], 1'b0);
        send(1, 1'b1, 8'h04, 8'h44);
        repeat (12) @(posedge clk);
        #1;
        chk("t5_write_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("t5_write_%0d", i), (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
        end

        // Second read held off until the first read's valid pulse
        send(1, 1'b0, 8'h50, 8'h00);
        chk("t6_listo_pending", listo[1], 1'b0);
        req[1] = 1'b1; lw[1] = 1'b0; addr[1] = 8'h51;
        acc_at = 0; seen = 1'b0; cap = '0;
        for (int i = 1; i <= 20; i++) begin
            l = listo[1];
            @(posedge clk); #1;
            if (l) begin acc_at = i; break; end
            if (valid[1]) begin seen = 1'b1; cap = dout[1]; end
        end
        req[1] = 1'b0;
        chk("t6_accept_edge", acc_at, 4);
        chk("t6_first_valid", seen, 1'b1);
        chk("t6_first_data", cap, 8'hD3);
        edge_at = 0; cap = '0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (valid[1] && edge_at == 0) begin edge_at = i; cap = dout[1]; end
        end
        chk("t6_second_edge", edge_at, 3);
        chk("t6_second_data", cap, 8'hD2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
